// File: rtl/write_sm.sv
// Write-path controller: requests the bus, pops one FIFO word, loads and shifts
// it out until the bit counter completes, then advances the destination select.
`timescale 1ns/1ps
module write_sm (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_w,
  output logic       rst_cntr_w,
  output logic       rst_w,
  output logic       bs_rqst,
  output logic       ps_w,
  output logic       en_w,
  output logic       pop,
  output logic [1:0] s_ds_w,
  output logic       bs_bsy_pre
);

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  logic [2:0] cur_e;
  logic [2:0] fut_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_e <= S_RST;
    else      cur_e <= fut_e;
  end

  // Destination advances as the word completes, so each pop maps to one select value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 s_ds_w <= 2'd0;
    else if (cur_e == S_NEXT) s_ds_w <= s_ds_w + 2'd1;
  end

  always_comb begin
    fut_e = S_RST;
    case (cur_e)
      S_RST:   fut_e = S_REQ;
      S_REQ:   fut_e = S_POP;
      S_POP:   fut_e = S_SHIFT;
      S_SHIFT: fut_e = c_w ? S_NEXT : S_SHIFT;
      S_NEXT:  fut_e = S_REQ;
      default: fut_e = S_RST;
    endcase
  end

  always_comb begin
    rst_cntr_w = 1'b0;
    rst_w      = 1'b0;
    bs_rqst    = 1'b0;
    ps_w       = 1'b0;
    en_w       = 1'b0;
    pop        = 1'b0;
    bs_bsy_pre = 1'b0;
    case (cur_e)
      S_RST: begin
        rst_w      = 1'b1;
        rst_cntr_w = 1'b1;
      end
      S_REQ: begin
        bs_rqst    = 1'b1;
        bs_bsy_pre = 1'b1;
      end
      S_POP: begin
        pop        = 1'b1;
        ps_w       = 1'b1;
        rst_cntr_w = 1'b1;
        bs_bsy_pre = 1'b1;
      end
      S_SHIFT: begin
        en_w       = 1'b1;
        bs_bsy_pre = 1'b1;
      end
      S_NEXT:  rst_cntr_w = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_write_sm.sv
// Directed bench for write_sm: reset, fixed and minimum transfer loops,
// asynchronous c_w activity, mid-transfer reset and an illegal state.
`timescale 1ns/1ps
module tb_write_sm;

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  logic       clk_tb;
  logic       rst;
  logic       c_w;
  logic       rst_cntr_w, rst_w, bs_rqst, ps_w, en_w, pop, bs_bsy_pre;
  logic [1:0] s_ds_w;
  logic [6:0] outs;

  int n_chk = 0;
  int n_err = 0;
  int en_cnt = 0;
  int pop_cnt = 0;
  bit tog_en = 1'b0;

  write_sm dut (
    .clk        (clk_tb),
    .rst        (rst),
    .c_w        (c_w),
    .rst_cntr_w (rst_cntr_w),
    .rst_w      (rst_w),
    .bs_rqst    (bs_rqst),
    .ps_w       (ps_w),
    .en_w       (en_w),
    .pop        (pop),
    .s_ds_w     (s_ds_w),
    .bs_bsy_pre (bs_bsy_pre)
  );

  assign outs = {rst_cntr_w, rst_w, bs_rqst, ps_w, en_w, pop, bs_bsy_pre};

  initial clk_tb = 1'b0;
  always #2 clk_tb = ~clk_tb;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // {rst_cntr_w, rst_w, bs_rqst, ps_w, en_w, pop, bs_bsy_pre}
  function automatic logic [6:0] exp_outs(input logic [2:0] st);
    case (st)
      S_RST:   return 7'b1100000;
      S_REQ:   return 7'b0010001;
      S_POP:   return 7'b1001011;
      S_SHIFT: return 7'b0000101;
      S_NEXT:  return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [2:0] nxt(input logic [2:0] st, input logic cw);
    case (st)
      S_RST:   return S_REQ;
      S_REQ:   return S_POP;
      S_POP:   return S_SHIFT;
      S_SHIFT: return cw ? S_NEXT : S_SHIFT;
      S_NEXT:  return S_REQ;
      default: return S_RST;
    endcase
  endfunction

  task automatic step(input logic [2:0] st, input logic [1:0] ds, input string tag);
    @(posedge clk_tb);
    #1;
    chk({tag, "_state"}, {29'd0, dut.cur_e}, {29'd0, st});
    chk({tag, "_outs"}, {25'd0, outs}, {25'd0, exp_outs(st)});
    chk({tag, "_ds"}, {30'd0, s_ds_w}, {30'd0, ds});
    en_cnt  += int'(en_w);
    pop_cnt += int'(pop);
  endtask

  initial begin
    logic [2:0] exp_st;
    logic [1:0] eds;
    logic       cw;
    logic [2:0] seq [4];
    seq[0] = S_POP; seq[1] = S_SHIFT; seq[2] = S_NEXT; seq[3] = S_REQ;

    // Reset held for three edges
    rst = 1'b0;
    c_w = 1'b0;
    repeat (3) @(posedge clk_tb);
    @(negedge clk_tb);
    chk("rst_state", {29'd0, dut.cur_e}, 32'd0);
    chk("rst_ds", {30'd0, s_ds_w}, 32'd0);
    chk("rst_outs", {25'd0, outs}, 32'h60);
    rst = 1'b1;
    step(S_REQ, 2'd0, "rel");
    chk("rel_bs_rqst", {31'd0, bs_rqst}, 32'd1);

    // Fixed-length shift: five SHIFT cycles
    en_cnt = 0; pop_cnt = 0;
    step(S_POP, 2'd0, "fix_pop");
    for (int k = 0; k < 5; k++) begin
      step(S_SHIFT, 2'd0, "fix_shift");
      if (k == 4) c_w = 1'b1;
    end
    step(S_NEXT, 2'd0, "fix_next");
    step(S_REQ, 2'd1, "fix_req");
    chk("fix_en_cnt", en_cnt, 32'd5);
    chk("fix_pop_cnt", pop_cnt, 32'd1);

    // Minimum 4-cycle loop with c_w held high; select wraps 3 -> 0
    pop_cnt = 0;
    eds = 2'd1;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 3) eds = eds + 2'd1;
      step(seq[i % 4], eds, "loop");
    end
    chk("loop_pop_cnt", pop_cnt, 32'd4);
    chk("loop_ds_end", {30'd0, s_ds_w}, 32'd1);

    // c_w toggling every 6 ns, never on a clock edge
    exp_st = S_REQ;
    eds = 2'd1;
    #2;
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          c_w = ~c_w;
          #6;
        end
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_tb);
      cw = c_w;
      if (exp_st == S_NEXT) eds = eds + 2'd1;
      exp_st = nxt(exp_st, cw);
      #1;
      chk("tog_state", {29'd0, dut.cur_e}, {29'd0, exp_st});
      chk("tog_outs", {25'd0, outs}, {25'd0, exp_outs(exp_st)});
      chk("tog_ds", {30'd0, s_ds_w}, {30'd0, eds});
      @(negedge clk_tb);
      chk("tog_mid_outs", {25'd0, outs}, {25'd0, exp_outs(exp_st)});
    end
    tog_en = 1'b0;
    #8;

    // Reset mid-SHIFT with select at 2
    rst = 1'b0;
    #1;
    chk("r2_state", {29'd0, dut.cur_e}, 32'd0);
    @(negedge clk_tb);
    rst = 1'b1;
    c_w = 1'b1;
    step(S_REQ, 2'd0, "m_req0");
    step(S_POP, 2'd0, "m_pop0");
    step(S_SHIFT, 2'd0, "m_sh0");
    step(S_NEXT, 2'd0, "m_nx0");
    step(S_REQ, 2'd1, "m_req1");
    step(S_POP, 2'd1, "m_pop1");
    step(S_SHIFT, 2'd1, "m_sh1");
    step(S_NEXT, 2'd1, "m_nx1");
    step(S_REQ, 2'd2, "m_req2");
    c_w = 1'b0;
    step(S_POP, 2'd2, "m_pop2");
    step(S_SHIFT, 2'd2, "m_sh2");
    chk("m_en_before", {31'd0, en_w}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("m_async_state", {29'd0, dut.cur_e}, 32'd0);
    chk("m_async_ds", {30'd0, s_ds_w}, 32'd0);
    chk("m_async_en", {31'd0, en_w}, 32'd0);
    chk("m_async_outs", {25'd0, outs}, 32'h60);
    @(negedge clk_tb);
    rst = 1'b1;
    step(S_REQ, 2'd0, "m_rel");

    // Illegal encoding 6: all outputs low, next state S_RST
    #1;
    force dut.cur_e = 3'd6;
    #1;
    chk("ill_outs", {25'd0, outs}, 32'd0);
    chk("ill_fut", {29'd0, dut.fut_e}, 32'd0);
    release dut.cur_e;
    rst = 1'b0;
    #1;
    chk("ill_rst_state", {29'd0, dut.cur_e}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
